// File: rtl/score_bin_to_bcd.sv
// Sequential double-dabble converter: binary game score -> packed BCD for the LED driver.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - conversion request, sampled only while ready=1
//   bin_value   - binary score, latched on the accepting edge
//   ready/busy  - idle indicator and its complement
//   done        - one-cycle pulse when BCD_bits/overflow are updated
//   overflow    - last accepted value exceeded 10^DIGITS-1
//   BCD_bits    - packed BCD result, digit 0 in [3:0], held until the next done
module score_bin_to_bcd #(
    parameter int unsigned BIN_WIDTH = 27,
    parameter int unsigned DIGITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_value,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   BCD_bits
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + BIN_WIDTH;
    localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    // 10^digits - 1 built from shifts and adds at elaboration time
    function automatic logic [63:0] max_val_f(input int unsigned digits);
        logic [63:0] v;
        v = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = (v << 3) + (v << 1);
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_val_f(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sat_q, sat_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;

    logic [BCD_W-1:0]       adj;
    logic [CAT_W-1:0]       cat;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        sat_d     = sat_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        adj       = scratch_q;
        cat       = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d   = bin_value;
                    scratch_d = '0;
                    count_d   = '0;
                    sat_d     = (64'(bin_value) > MAX_VAL);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // add-3 on every nibble >= 5, then shift the whole {scratch, shreg} left
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (scratch_q[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
                    end
                end
                cat       = {adj, shreg_q} << 1;
                scratch_d = cat[CAT_W-1:BIN_WIDTH];
                shreg_d   = cat[BIN_WIDTH-1:0];
                count_d   = count_q + CNT_W'(1);
                if (count_q == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // saturated runs discard the scratch contents entirely
                bcd_d   = sat_q ? {DIGITS{4'h9}} : scratch_q;
                ovf_d   = sat_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign BCD_bits = bcd_q;

endmodule

// File: tb/tb_score_bin_to_bcd.sv
// Directed bench for score_bin_to_bcd: vector table plus multi-cycle corner sequences.
module tb_score_bin_to_bcd;

    localparam int unsigned BW  = 27;
    localparam int unsigned DG  = 8;
    localparam int unsigned LAT = BW + 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [BW-1:0]   bin_value;
    logic            ready;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [4*DG-1:0] BCD_bits;

    int n_checks;
    int n_fail;

    score_bin_to_bcd #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bin_value (bin_value),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .BCD_bits  (BCD_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0]   bin;
        logic [4*DG-1:0] bcd;
        logic            ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One conversion with start pulsed for a single cycle; bin_value scrambled after acceptance
    task automatic run_conv(input logic [BW-1:0] v, output int lat, output logic [4*DG-1:0] bcd,
                            output logic ovf, output int busy_err, output logic done_after);
        lat      = 0;
        busy_err = 0;
        @(negedge clk);
        start     = 1'b1;
        bin_value = v;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        bin_value = ~v;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (ready !== 1'b0 || busy !== 1'b1) busy_err++;
        end
        bcd = BCD_bits;
        ovf = overflow;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    initial begin
        int              lat;
        int              berr;
        logic [4*DG-1:0] bcd;
        logic            ovf;
        logic            dafter;
        int              ndone;
        int              lat_rec;
        logic [4*DG-1:0] bcd_rec;
        logic [BW-1:0]   seq_vals[3];
        logic [4*DG-1:0] seq_exp[3];
        int              t_done[3];
        int              k;
        int              cyc;
        int              stable_err;
        logic [4*DG-1:0] last_bcd;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{27'd0,         32'h00000000, 1'b0};
        vecs[1]  = '{27'd12345678,  32'h12345678, 1'b0};
        vecs[2]  = '{27'd99999999,  32'h99999999, 1'b0};
        vecs[3]  = '{27'd100000000, 32'h99999999, 1'b1};
        vecs[4]  = '{27'd134217727, 32'h99999999, 1'b1};
        vecs[5]  = '{27'd1,         32'h00000001, 1'b0};
        vecs[6]  = '{27'd9,         32'h00000009, 1'b0};
        vecs[7]  = '{27'd10,        32'h00000010, 1'b0};
        vecs[8]  = '{27'd99,        32'h00000099, 1'b0};
        vecs[9]  = '{27'd1000,      32'h00001000, 1'b0};
        vecs[10] = '{27'd42,        32'h00000042, 1'b0};
        vecs[11] = '{27'd65535,     32'h00065535, 1'b0};

        // reset state
        rst_n     = 1'b0;
        start     = 1'b0;
        bin_value = '0;
        #12;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_bcd", 64'(BCD_bits), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven conversions
        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].bin, lat, bcd, ovf, berr, dafter);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("v%0d_bcd", i), 64'(bcd), 64'(vecs[i].bcd));
            chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
            chk($sformatf("v%0d_busy_window", i), 64'(berr), 64'd0);
            chk($sformatf("v%0d_done_width", i), 64'(dafter), 64'd0);
        end

        // reset mid-conversion aborts with no done pulse
        @(negedge clk);
        start     = 1'b1;
        bin_value = 27'd777;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_bcd", 64'(BCD_bits), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        // start re-pulsed while busy with a new value: ignored
        @(negedge clk);
        start     = 1'b1;
        bin_value = 27'd4321;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        bin_value = 27'd8765;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        ndone   = 0;
        lat_rec = 0;
        bcd_rec = '0;
        for (int c = 6; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                lat_rec = c;
                bcd_rec = BCD_bits;
            end
        end
        chk("busy_start_ndone", 64'(ndone), 64'd1);
        chk("busy_start_latency", 64'(lat_rec), 64'(LAT));
        chk("busy_start_bcd", 64'(bcd_rec), 64'h00004321);

        // start held high: back-to-back conversions
        seq_vals[0] = 27'd5;  seq_exp[0] = 32'h00000005;
        seq_vals[1] = 27'd10; seq_exp[1] = 32'h00000010;
        seq_vals[2] = 27'd99; seq_exp[2] = 32'h00000099;
        t_done[0] = 0; t_done[1] = 0; t_done[2] = 0;
        k          = 0;
        cyc        = 0;
        stable_err = 0;
        last_bcd   = BCD_bits;
        @(negedge clk);
        start     = 1'b1;
        bin_value = seq_vals[0];
        while (k < 3 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                t_done[k] = cyc;
                chk($sformatf("b2b_bcd%0d", k), 64'(BCD_bits), 64'(seq_exp[k]));
                last_bcd = BCD_bits;
                k++;
                if (k < 3) bin_value = seq_vals[k];
                else       start = 1'b0;
            end else if (BCD_bits !== last_bcd) begin
                stable_err++;
            end
        end
        chk("b2b_pulses", 64'(k), 64'd3);
        // accept edge, BW shift edges, one load edge per conversion
        chk("b2b_gap01", 64'(t_done[1] - t_done[0]), 64'(LAT + 1));
        chk("b2b_gap12", 64'(t_done[2] - t_done[1]), 64'(LAT + 1));
        chk("b2b_stable", 64'(stable_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
